prog_ctr_ras: RTL and testbench
===============================

PROG_CTR_RAS -- requirements
Module: prog_ctr_ras

Interface
REQ-001 Parameter A, 10, instruction-memory address width in bits.
REQ-002 Parameter OFFW, 8, relative-branch offset width in bits, two's complement, OFFW <= A.
REQ-003 Parameter D, 4, return-address stack depth in entries, D >= 1.
REQ-004 Clk  in  1  sole clock; all state changes on posedge Clk.
REQ-005 ResetN  in  1  asynchronous, active-low reset.
REQ-006 Start  in  1  testbench start request; level, may stay high for multiple cycles.
REQ-007 Halt  in  1  end-of-program request from decode.
REQ-008 Stall  in  1  freeze PC and stack this cycle.
REQ-009 BrOp  in  3  control-flow op: NONE=0, REL=1, ABS=2, CALL=3, RET=4; 5-7 reserved.
REQ-010 Offset  in  OFFW  signed relative-branch offset.
REQ-011 Target  in  A  absolute target for ABS/CALL.
REQ-012 ProgCtr  out  A  program counter register.
REQ-013 Going  out  1  high iff state RUN.
REQ-014 Done  out  1  high iff state HALTED.
REQ-015 Depth  out  $clog2(D+1)  current stack occupancy.
REQ-016 StackErr  out  1  sticky overflow/underflow flag.

Function
REQ-017 The FSM SHALL have states IDLE, ARMED, RUN and HALTED; Going, Done and ProgCtr SHALL be registered outputs.
REQ-018 IDLE: Start=1 -> ARMED; otherwise remain in IDLE.
REQ-019 ARMED: remain in ARMED while Start=1; Start=0 -> RUN on the next edge.
REQ-020 ProgCtr, stack and StackErr SHALL NOT change in IDLE, ARMED or HALTED, except as stated in REQ-029.
REQ-021 RUN with Halt=1: transition to HALTED; ProgCtr is held; BrOp and Stall are ignored. Halt SHALL have priority over Stall and BrOp.
REQ-022 RUN with Halt=0 and Stall=1: ProgCtr, stack and StackErr are held.
REQ-023 RUN with Halt=0 and Stall=0, per BrOp:
- NONE or reserved encoding: ProgCtr+1.
- REL: ProgCtr + sign-extended Offset.
- ABS: Target.
- CALL: push ProgCtr+1, then load Target.
- RET: pop, then load the popped value.
REQ-024 All PC arithmetic SHALL be modulo 2^A; 2^A-1 +1 -> 0; 0 + (-1) -> 2^A-1.
REQ-025 CALL with Depth==D: ProgCtr SHALL load Target; the push is discarded; stack contents are unchanged; StackErr is set.
REQ-026 RET with Depth==0: ProgCtr SHALL increment by 1 (ProgCtr+1); StackErr is set.
REQ-027 Depth SHALL increment on each successful CALL, decrement on each successful RET, and otherwise hold.
REQ-028 StackErr SHALL stay set until reset or a restart.
REQ-029 HALTED with Start=1: transition to ARMED; on the same edge, clear ProgCtr to 0, clear Depth to 0 and clear StackErr.

Reset
REQ-030 While ResetN=0, the block SHALL be in state IDLE with ProgCtr=0, Going=0, Done=0, Depth=0 and StackErr=0, regardless of Clk.
REQ-031 Reset assertion mid-RUN SHALL abort immediately; stack entry contents are don't-care, and Depth=0 SHALL make them invisible.
REQ-032 After ResetN rises, the first state change SHALL occur on a posedge Clk; Start sampled high on that edge moves IDLE to ARMED.

Structure
REQ-033 Package prog_ctr_pkg SHALL hold the br_op_e enum (3-bit) and the pc_state_e enum; default parameter values are localparams in the same package.
REQ-034 Sub-module ret_stack SHALL implement a width-A, depth-D LIFO.
- Ports: push, pop, din, dout, count, full, empty.
- Uses the same Clk/ResetN.
- Overflow/underflow protection lives in prog_ctr_ras, not in ret_stack.

Verification
REQ-035 Start high for 3 cycles, then low -> Going=0 until 1 cycle after Start falls; then ProgCtr counts 0,1,2,3 on successive edges.
REQ-036 A=10, ProgCtr=1023, BrOp=NONE -> ProgCtr=0; ProgCtr=5, REL, Offset=8'hFA (-6) -> ProgCtr=1023.
REQ-037 ProgCtr=10, CALL Target=100; then NONE x2; then RET -> sequence 100,101,102,11; Depth goes 1 then 0; StackErr=0.
REQ-038 D=4, five nested CALLs -> Depth=4 and StackErr=1; four RETs return the first four return addresses (LIFO order); a fifth RET -> ProgCtr+1, StackErr stays 1.
REQ-039 Stall=1 with BrOp=CALL for 2 cycles -> ProgCtr and Depth unchanged; Halt=1 with Stall=1 -> Done=1 on the next edge, ProgCtr held.
REQ-040 ResetN pulsed low mid-RUN (ProgCtr=37, Depth=2) -> ProgCtr=0, Depth=0, Going=0 without a clock edge; HALTED followed by Start -> ProgCtr=0, StackErr=0.

Source files
------------

// File: rtl/prog_ctr_pkg.sv
// rtl/prog_ctr_pkg.sv - shared types and default parameters for the program counter
package prog_ctr_pkg;

  localparam int A_DEF    = 10;
  localparam int OFFW_DEF = 8;
  localparam int D_DEF    = 4;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_REL  = 3'd1,
    BR_ABS  = 3'd2,
    BR_CALL = 3'd3,
    BR_RET  = 3'd4
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } pc_state_e;

endpackage

// File: rtl/prog_ctr_ras_if.sv
// rtl/prog_ctr_ras_if.sv - control and status bundle between decode and the program counter
interface prog_ctr_ras_if import prog_ctr_pkg::*; #(
  parameter int A    = A_DEF,
  parameter int OFFW = OFFW_DEF,
  parameter int D    = D_DEF
);
  logic                     Start;
  logic                     Halt;
  logic                     Stall;
  logic [2:0]               BrOp;
  logic [OFFW-1:0]          Offset;
  logic [A-1:0]             Target;
  logic [A-1:0]             ProgCtr;
  logic                     Going;
  logic                     Done;
  logic [$clog2(D+1)-1:0]   Depth;
  logic                     StackErr;

  modport master (
    output Start, Halt, Stall, BrOp, Offset, Target,
    input  ProgCtr, Going, Done, Depth, StackErr
  );

  modport slave (
    input  Start, Halt, Stall, BrOp, Offset, Target,
    output ProgCtr, Going, Done, Depth, StackErr
  );
endinterface

// File: rtl/prog_ctr_ras_ret_stack.sv
// rtl/prog_ctr_ras_ret_stack.sv - return-address LIFO; caller guards against overflow/underflow
module ret_stack import prog_ctr_pkg::*; #(
  parameter int A = A_DEF,
  parameter int D = D_DEF
) (
  input  logic                   Clk,
  input  logic                   ResetN,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [A-1:0]           din,
  output logic [A-1:0]           dout,
  output logic [$clog2(D+1)-1:0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int CW = $clog2(D + 1);
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  logic [A-1:0]  mem [D];
  logic [CW-1:0] top_idx;

  // Entry contents need no reset: a zero count makes them unreachable.
  assign top_idx = count - CW'(1);
  assign dout    = mem[top_idx[IW-1:0]];
  assign full    = (count == CW'(D));
  assign empty   = (count == '0);

  always_ff @(posedge Clk) begin
    if (push && !clear) begin
      mem[count[IW-1:0]] <= din;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/prog_ctr_ras.sv
// rtl/prog_ctr_ras.sv - program counter with run/halt FSM and return-address stack
module prog_ctr_ras import prog_ctr_pkg::*; #(
  parameter int A    = A_DEF,
  parameter int OFFW = OFFW_DEF,
  parameter int D    = D_DEF
) (
  input logic          Clk,
  input logic          ResetN,
  prog_ctr_ras_if.slave bus
);
  localparam int CW = $clog2(D + 1);

  pc_state_e     state, state_nxt;
  logic [A-1:0]  pc_q, pc_nxt;
  logic          err_q, err_nxt;
  logic          going_q, done_q;
  logic          push, pop, clr;
  logic [A-1:0]  off_ext;
  logic [A-1:0]  stk_dout;
  logic [CW-1:0] stk_count;
  logic          stk_full, stk_empty;

  assign off_ext = A'($signed(bus.Offset));

  ret_stack #(.A(A), .D(D)) u_stack (
    .Clk    (Clk),
    .ResetN (ResetN),
    .clear  (clr),
    .push   (push),
    .pop    (pop),
    .din    (pc_q + A'(1)),
    .dout   (stk_dout),
    .count  (stk_count),
    .full   (stk_full),
    .empty  (stk_empty)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    err_nxt   = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    case (state)
      ST_IDLE:  if (bus.Start) state_nxt = ST_ARMED;
      ST_ARMED: if (!bus.Start) state_nxt = ST_RUN;
      ST_RUN: begin
        // Halt outranks Stall and any branch in the same cycle.
        if (bus.Halt) begin
          state_nxt = ST_HALTED;
        end else if (!bus.Stall) begin
          case (bus.BrOp)
            BR_REL: pc_nxt = pc_q + off_ext;
            BR_ABS: pc_nxt = bus.Target;
            BR_CALL: begin
              pc_nxt = bus.Target;
              if (stk_full) err_nxt = 1'b1;
              else          push    = 1'b1;
            end
            BR_RET: begin
              if (stk_empty) begin
                pc_nxt  = pc_q + A'(1);
                err_nxt = 1'b1;
              end else begin
                pc_nxt = stk_dout;
                pop    = 1'b1;
              end
            end
            default: pc_nxt = pc_q + A'(1);
          endcase
        end
      end
      ST_HALTED: begin
        if (bus.Start) begin
          state_nxt = ST_ARMED;
          pc_nxt    = '0;
          err_nxt   = 1'b0;
          clr       = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= ST_IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
      going_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      err_q   <= err_nxt;
      going_q <= (state_nxt == ST_RUN);
      done_q  <= (state_nxt == ST_HALTED);
    end
  end

  assign bus.ProgCtr  = pc_q;
  assign bus.Going    = going_q;
  assign bus.Done     = done_q;
  assign bus.Depth    = stk_count;
  assign bus.StackErr = err_q;
endmodule

// File: tb/tb_prog_ctr_ras.sv
// tb/tb_prog_ctr_ras.sv - directed scoreboard bench for prog_ctr_ras
module tb_prog_ctr_ras;
  import prog_ctr_pkg::*;

  typedef struct {
    string      tag;
    logic [9:0] pc;
    logic [2:0] depth;
    logic       err;
    logic       going;
    logic       done;
  } exp_t;

  logic Clk;
  logic ResetN;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  prog_ctr_ras_if #(.A(10), .OFFW(8), .D(4)) bus ();

  prog_ctr_ras #(.A(10), .OFFW(8), .D(4)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int pc, input int dp,
                              input bit er, input bit go, input bit dn);
    exp_t e;
    e.tag = tag; e.pc = pc[9:0]; e.depth = dp[2:0];
    e.err = er; e.going = go; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"},    32'(bus.ProgCtr),  32'(e.pc));
      check({e.tag, ".depth"}, 32'(bus.Depth),    32'(e.depth));
      check({e.tag, ".err"},   32'(bus.StackErr), 32'(e.err));
      check({e.tag, ".going"}, 32'(bus.Going),    32'(e.going));
      check({e.tag, ".done"},  32'(bus.Done),     32'(e.done));
    end
  endtask

  task automatic drv(input bit st, input bit hl, input bit sl,
                     input br_op_e op, input int off, input int tgt);
    bus.Start  = st;
    bus.Halt   = hl;
    bus.Stall  = sl;
    bus.BrOp   = op;
    bus.Offset = off[7:0];
    bus.Target = tgt[9:0];
  endtask

  task automatic step(input string tag, input int pc, input int dp,
                      input bit er, input bit go, input bit dn);
    expect_state(tag, pc, dp, er, go, dn);
    @(posedge Clk);
    #1;
    compare_front();
  endtask

  initial begin
    ResetN = 1'b0;
    drv(0, 0, 0, BR_NONE, 0, 0);
    #2;
    expect_state("reset", 0, 0, 0, 0, 0);
    compare_front();

    @(negedge Clk);
    ResetN = 1'b1;
    drv(1, 0, 0, BR_NONE, 0, 0);
    step("armed1", 0, 0, 0, 0, 0);
    step("armed2", 0, 0, 0, 0, 0);
    step("armed3", 0, 0, 0, 0, 0);
    drv(0, 0, 0, BR_NONE, 0, 0);
    step("run0", 0, 0, 0, 1, 0);
    step("cnt1", 1, 0, 0, 1, 0);
    step("cnt2", 2, 0, 0, 1, 0);
    step("cnt3", 3, 0, 0, 1, 0);

    drv(0, 0, 0, BR_ABS, 0, 1023);
    step("abs1023", 1023, 0, 0, 1, 0);
    drv(0, 0, 0, BR_NONE, 0, 0);
    step("wrap_inc", 0, 0, 0, 1, 0);
    drv(0, 0, 0, BR_ABS, 0, 5);
    step("abs5", 5, 0, 0, 1, 0);
    drv(0, 0, 0, BR_REL, 8'hFA, 0);
    step("rel_neg", 1023, 0, 0, 1, 0);
    drv(0, 0, 0, BR_REL, 8'h7F, 0);
    step("rel_pos", 126, 0, 0, 1, 0);
    bus.BrOp = 3'd7;
    step("reserved", 127, 0, 0, 1, 0);

    drv(0, 0, 0, BR_ABS, 0, 10);
    step("abs10", 10, 0, 0, 1, 0);
    drv(0, 0, 0, BR_CALL, 0, 100);
    step("call100", 100, 1, 0, 1, 0);
    drv(0, 0, 0, BR_NONE, 0, 0);
    step("seq101", 101, 1, 0, 1, 0);
    step("seq102", 102, 1, 0, 1, 0);
    drv(0, 0, 0, BR_RET, 0, 0);
    step("ret11", 11, 0, 0, 1, 0);

    drv(0, 0, 1, BR_CALL, 0, 200);
    step("stall1", 11, 0, 0, 1, 0);
    step("stall2", 11, 0, 0, 1, 0);

    drv(0, 0, 0, BR_CALL, 0, 20);
    step("nest1", 20, 1, 0, 1, 0);
    bus.Target = 10'd30;
    step("nest2", 30, 2, 0, 1, 0);
    bus.Target = 10'd40;
    step("nest3", 40, 3, 0, 1, 0);
    bus.Target = 10'd50;
    step("nest4", 50, 4, 0, 1, 0);
    bus.Target = 10'd60;
    step("overflow", 60, 4, 1, 1, 0);
    drv(0, 0, 0, BR_RET, 0, 0);
    step("pop41", 41, 3, 1, 1, 0);
    step("pop31", 31, 2, 1, 1, 0);
    step("pop21", 21, 1, 1, 1, 0);
    step("pop12", 12, 0, 1, 1, 0);
    step("underflow", 13, 0, 1, 1, 0);

    drv(0, 1, 1, BR_CALL, 0, 300);
    step("halt", 13, 0, 1, 0, 1);
    drv(0, 0, 0, BR_NONE, 0, 0);
    step("halt_hold", 13, 0, 1, 0, 1);
    drv(1, 0, 0, BR_NONE, 0, 0);
    step("restart", 0, 0, 0, 0, 0);
    drv(0, 0, 0, BR_NONE, 0, 0);
    step("rerun", 0, 0, 0, 1, 0);

    drv(0, 0, 0, BR_CALL, 0, 50);
    step("pre_call1", 50, 1, 0, 1, 0);
    bus.Target = 10'd36;
    step("pre_call2", 36, 2, 0, 1, 0);
    drv(0, 0, 0, BR_NONE, 0, 0);
    step("at37", 37, 2, 0, 1, 0);

    ResetN = 1'b0;
    #2;
    expect_state("async_rst", 0, 0, 0, 0, 0);
    compare_front();
    drv(1, 0, 0, BR_NONE, 0, 0);
    step("rst_hold", 0, 0, 0, 0, 0);
    @(negedge Clk);
    ResetN = 1'b1;
    step("post_rst_armed", 0, 0, 0, 0, 0);
    drv(0, 0, 0, BR_NONE, 0, 0);
    step("post_rst_run", 0, 0, 0, 1, 0);
    drv(0, 0, 0, BR_RET, 0, 0);
    step("empty_ret", 1, 0, 1, 1, 0);
    drv(0, 1, 0, BR_NONE, 0, 0);
    step("final_halt", 1, 0, 1, 0, 1);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
